// File: rtl/srio_seg_pkg.sv
// Shared types, default parameters and constant helpers for the SRIO transfer segmenter.
package srio_seg_pkg;

    localparam int unsigned DEF_ADDR_W      = 34;
    localparam int unsigned DEF_LEN_W       = 20;
    localparam int unsigned DEF_MAX_PAYLOAD = 256;
    localparam int unsigned DEF_MIN_PAYLOAD = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEG  = 2'd1,
        ST_TAIL = 2'd2
    } seg_state_e;

    // Ceiling log2 for elaboration-time width calculations.
    function automatic int unsigned log2_f(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = 32'(i + 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/srio_xfer_segmenter_if.sv
// Request and segment-descriptor handshake bundle for the SRIO transfer segmenter.
interface srio_xfer_segmenter_if
    import srio_seg_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned LEN_W       = DEF_LEN_W,
    parameter int unsigned MAX_PAYLOAD = DEF_MAX_PAYLOAD
);
    localparam int unsigned S     = log2_f(MAX_PAYLOAD);
    localparam int unsigned IDX_W = LEN_W - S;

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len_m1;

    logic              seg_valid;
    logic              seg_ready;
    logic [ADDR_W-1:0] seg_addr;
    logic [S:0]        seg_size;
    logic [S-1:0]      seg_pad;
    logic              seg_last;
    logic [IDX_W-1:0]  seg_idx;
    logic              err_unaligned;

    modport master (
        output req_valid, req_addr, req_len_m1, seg_ready,
        input  req_ready, seg_valid, seg_addr, seg_size, seg_pad, seg_last, seg_idx, err_unaligned
    );

    modport slave (
        input  req_valid, req_addr, req_len_m1, seg_ready,
        output req_ready, seg_valid, seg_addr, seg_size, seg_pad, seg_last, seg_idx, err_unaligned
    );

endinterface

// File: rtl/srio_round_pow2.sv
// Rounds a tail remainder (bytes minus one) up to a power-of-two segment size and its pad count.
module srio_round_pow2
    import srio_seg_pkg::*;
#(
    parameter int unsigned MIN_PAYLOAD = DEF_MIN_PAYLOAD,
    parameter int unsigned MAX_PAYLOAD = DEF_MAX_PAYLOAD
) (
    input  logic [log2_f(MAX_PAYLOAD)-1:0] rem,
    output logic [log2_f(MAX_PAYLOAD):0]   seg_size_c,
    output logic [log2_f(MAX_PAYLOAD)-1:0] seg_pad_c
);
    localparam int unsigned S    = log2_f(MAX_PAYLOAD);
    localparam int unsigned SZ_W = S + 1;

    // Descending scan leaves the smallest qualifying power of two.
    always_comb begin
        seg_size_c = SZ_W'(MAX_PAYLOAD);
        for (int i = int'(S); i >= 0; i--) begin
            if (((32'd1 << i) >= MIN_PAYLOAD) && ((32'd1 << i) > 32'(rem))) begin
                seg_size_c = SZ_W'(32'd1 << i);
            end
        end
        seg_pad_c = S'(seg_size_c - SZ_W'(rem) - SZ_W'(1));
    end

endmodule

// File: rtl/srio_xfer_segmenter.sv
// Splits a byte transfer request into MAX_PAYLOAD segments plus one power-of-two padded tail.
module srio_xfer_segmenter
    import srio_seg_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned LEN_W       = DEF_LEN_W,
    parameter int unsigned MAX_PAYLOAD = DEF_MAX_PAYLOAD,
    parameter int unsigned MIN_PAYLOAD = DEF_MIN_PAYLOAD
) (
    input  logic                  clk,
    input  logic                  reset_n,
    srio_xfer_segmenter_if.slave  bus
);
    localparam int unsigned S     = log2_f(MAX_PAYLOAD);
    localparam int unsigned SZ_W  = S + 1;
    localparam int unsigned IDX_W = LEN_W - S;

    seg_state_e        state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              seg_valid_q, seg_valid_d;
    logic [ADDR_W-1:0] seg_addr_q, seg_addr_d;
    logic [SZ_W-1:0]   seg_size_q, seg_size_d;
    logic [S-1:0]      seg_pad_q, seg_pad_d;
    logic              seg_last_q, seg_last_d;
    logic [IDX_W-1:0]  seg_idx_q, seg_idx_d;
    logic              err_q, err_d;
    logic [IDX_W-1:0]  fc_q, fc_d;
    logic [S-1:0]      rem_q, rem_d;

    logic [S-1:0]      rem_sel_c;
    logic [SZ_W-1:0]   tail_size_c;
    logic [S-1:0]      tail_pad_c;
    logic              accept_c;
    logic              seg_hs_c;

    // Round the incoming remainder at accept, the captured one afterwards.
    assign rem_sel_c = (state_q == ST_IDLE) ? bus.req_len_m1[S-1:0] : rem_q;
    assign accept_c  = bus.req_valid && req_ready_q;
    assign seg_hs_c  = seg_valid_q && bus.seg_ready;

    srio_round_pow2 #(
        .MIN_PAYLOAD (MIN_PAYLOAD),
        .MAX_PAYLOAD (MAX_PAYLOAD)
    ) u_round (
        .rem        (rem_sel_c),
        .seg_size_c (tail_size_c),
        .seg_pad_c  (tail_pad_c)
    );

    always_comb begin
        state_d     = state_q;
        seg_valid_d = seg_valid_q;
        seg_addr_d  = seg_addr_q;
        seg_size_d  = seg_size_q;
        seg_pad_d   = seg_pad_q;
        seg_last_d  = seg_last_q;
        seg_idx_d   = seg_idx_q;
        fc_d        = fc_q;
        rem_d       = rem_q;
        err_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    fc_d        = bus.req_len_m1[LEN_W-1:S];
                    rem_d       = bus.req_len_m1[S-1:0];
                    seg_addr_d  = {bus.req_addr[ADDR_W-1:3], 3'b000};
                    seg_idx_d   = '0;
                    seg_valid_d = 1'b1;
                    err_d       = (bus.req_addr[2:0] != 3'b000);
                    if (fc_d != '0) begin
                        state_d    = ST_SEG;
                        seg_size_d = SZ_W'(MAX_PAYLOAD);
                        seg_pad_d  = '0;
                        seg_last_d = 1'b0;
                    end else begin
                        state_d    = ST_TAIL;
                        seg_size_d = tail_size_c;
                        seg_pad_d  = tail_pad_c;
                        seg_last_d = 1'b1;
                    end
                end
            end
            ST_SEG: begin
                if (seg_hs_c) begin
                    seg_addr_d = seg_addr_q + ADDR_W'(MAX_PAYLOAD);
                    seg_idx_d  = seg_idx_q + IDX_W'(1);
                    if (seg_idx_d == fc_q) begin
                        state_d    = ST_TAIL;
                        seg_size_d = tail_size_c;
                        seg_pad_d  = tail_pad_c;
                        seg_last_d = 1'b1;
                    end
                end
            end
            ST_TAIL: begin
                if (seg_hs_c) begin
                    state_d     = ST_IDLE;
                    seg_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                seg_valid_d = 1'b0;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b0;
            seg_valid_q <= 1'b0;
            seg_addr_q  <= '0;
            seg_size_q  <= '0;
            seg_pad_q   <= '0;
            seg_last_q  <= 1'b0;
            seg_idx_q   <= '0;
            err_q       <= 1'b0;
            fc_q        <= '0;
            rem_q       <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            seg_valid_q <= seg_valid_d;
            seg_addr_q  <= seg_addr_d;
            seg_size_q  <= seg_size_d;
            seg_pad_q   <= seg_pad_d;
            seg_last_q  <= seg_last_d;
            seg_idx_q   <= seg_idx_d;
            err_q       <= err_d;
            fc_q        <= fc_d;
            rem_q       <= rem_d;
        end
    end

    assign bus.req_ready     = req_ready_q;
    assign bus.seg_valid     = seg_valid_q;
    assign bus.seg_addr      = seg_addr_q;
    assign bus.seg_size      = seg_size_q;
    assign bus.seg_pad       = seg_pad_q;
    assign bus.seg_last      = seg_last_q;
    assign bus.seg_idx       = seg_idx_q;
    assign bus.err_unaligned = err_q;

endmodule

// File: tb/tb_srio_xfer_segmenter.sv
// Directed bench: a 256-byte and a 128-byte segmenter checked against a transfer-level segment model.
module tb_srio_xfer_segmenter;

    localparam longint AMASK = 64'h3_FFFF_FFFF;

    typedef struct {
        longint addr;
        int     size;
        int     pad;
        bit     last;
        int     idx;
    } exp_t;

    logic clk;
    logic reset_n;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qs[$];
    bit   stalled [2];

    srio_xfer_segmenter_if #(.ADDR_W(34), .LEN_W(20), .MAX_PAYLOAD(256)) bus_a ();
    srio_xfer_segmenter_if #(.ADDR_W(34), .LEN_W(20), .MAX_PAYLOAD(128)) bus_b ();

    srio_xfer_segmenter #(.ADDR_W(34), .LEN_W(20), .MAX_PAYLOAD(256), .MIN_PAYLOAD(8)) u_dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_a)
    );

    srio_xfer_segmenter #(.ADDR_W(34), .LEN_W(20), .MAX_PAYLOAD(128), .MIN_PAYLOAD(8)) u_dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void qpush(input int w, input exp_t e);
        if (w == 0) qa.push_back(e);
        else if (w == 1) qb.push_back(e);
        else qs.push_back(e);
    endfunction

    function automatic int qsize(input int w);
        return (w == 0) ? qa.size() : qb.size();
    endfunction

    // Transfer-level model: full segments, then the tail rounded to a power of two >= 8.
    function automatic void model_push(input int w, input longint addr, input longint len, input int max);
        longint fc   = len / max;
        longint r    = len % max;
        longint base = addr - (addr % 8);
        int     p    = 8;
        exp_t   e;
        for (longint n = 0; n < fc; n++) begin
            e.addr = (base + n * max) & AMASK;
            e.size = max;
            e.pad  = 0;
            e.last = 1'b0;
            e.idx  = int'(n);
            qpush(w, e);
        end
        while (p < r + 1) p = p * 2;
        e.addr = (base + fc * max) & AMASK;
        e.size = p;
        e.pad  = p - 1 - int'(r);
        e.last = 1'b1;
        e.idx  = int'(fc);
        qpush(w, e);
    endfunction

    function automatic logic get_valid(input int w);
        return (w == 0) ? bus_a.seg_valid : bus_b.seg_valid;
    endfunction

    function automatic logic get_req_ready(input int w);
        return (w == 0) ? bus_a.req_ready : bus_b.req_ready;
    endfunction

    function automatic logic get_err(input int w);
        return (w == 0) ? bus_a.err_unaligned : bus_b.err_unaligned;
    endfunction

    task automatic set_rdy(input int w, input logic v);
        if (w == 0) bus_a.seg_ready = v;
        else bus_b.seg_ready = v;
    endtask

    task automatic cmp(input int w, input logic v, input logic r, input longint addr,
                       input int size, input int pad, input logic last, input int idx);
        exp_t e;
        if (stalled[w] && !v) chk($sformatf("dut%0d valid dropped while stalled", w), 0, 1);
        stalled[w] = v && !r;
        if (!v) return;
        if (qsize(w) == 0) begin
            chk($sformatf("dut%0d unexpected segment", w), 1, 0);
            return;
        end
        e = (w == 0) ? qa[0] : qb[0];
        chk($sformatf("dut%0d seg%0d addr", w, e.idx), addr, e.addr);
        chk($sformatf("dut%0d seg%0d size", w, e.idx), size, e.size);
        chk($sformatf("dut%0d seg%0d pad", w, e.idx), pad, e.pad);
        chk($sformatf("dut%0d seg%0d last", w, e.idx), last, e.last);
        chk($sformatf("dut%0d seg%0d idx", w, e.idx), idx, e.idx);
        if (r) begin
            if (w == 0) void'(qa.pop_front());
            else void'(qb.pop_front());
        end
    endtask

    // Every cycle with a descriptor on offer is checked against the model head.
    always @(negedge clk) begin
        if (!reset_n) begin
            stalled[0] = 1'b0;
            stalled[1] = 1'b0;
        end else begin
            cmp(0, bus_a.seg_valid, bus_a.seg_ready, 64'(bus_a.seg_addr), int'(bus_a.seg_size),
                int'(bus_a.seg_pad), bus_a.seg_last, int'(bus_a.seg_idx));
            cmp(1, bus_b.seg_valid, bus_b.seg_ready, 64'(bus_b.seg_addr), int'(bus_b.seg_size),
                int'(bus_b.seg_pad), bus_b.seg_last, int'(bus_b.seg_idx));
        end
    end

    task automatic send_req(input int w, input longint addr, input longint len);
        bit done = 1'b0;
        if (w == 0) begin
            bus_a.req_valid = 1'b1; bus_a.req_addr = 34'(addr); bus_a.req_len_m1 = 20'(len);
        end else begin
            bus_b.req_valid = 1'b1; bus_b.req_addr = 34'(addr); bus_b.req_len_m1 = 20'(len);
        end
        for (int c = 0; c < 20 && !done; c++) begin
            if (get_req_ready(w)) done = 1'b1;
            @(posedge clk); #1;
        end
        bus_a.req_valid = 1'b0;
        bus_b.req_valid = 1'b0;
        if (!done) chk($sformatf("dut%0d request accept timeout", w), 0, 1);
    endtask

    task automatic run_xfer(input int w, input longint addr, input longint len, input int max,
                            input bit toggle);
        bit exp_err = ((addr % 8) != 0);
        model_push(w, addr, len, max);
        send_req(w, addr, len);
        for (int c = 0; c < 400 && qsize(w) > 0; c++) begin
            set_rdy(w, toggle ? logic'(c % 2 == 1) : 1'b1);
            @(negedge clk);
            if (c == 0) begin
                chk($sformatf("dut%0d first valid after accept", w), get_valid(w), 1);
                chk($sformatf("dut%0d err_unaligned pulse", w), get_err(w), exp_err);
            end
            @(posedge clk); #1;
        end
        chk($sformatf("dut%0d segments left after drain", w), qsize(w), 0);
        chk($sformatf("dut%0d err_unaligned cleared", w), get_err(w), 0);
        chk($sformatf("dut%0d valid low after tail", w), get_valid(w), 0);
        chk($sformatf("dut%0d req_ready after tail", w), get_req_ready(w), 1);
        set_rdy(w, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL global timeout at %0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        reset_n = 1'b0;
        bus_a.req_valid = 1'b0; bus_a.req_addr = '0; bus_a.req_len_m1 = '0; bus_a.seg_ready = 1'b1;
        bus_b.req_valid = 1'b0; bus_b.req_addr = '0; bus_b.req_len_m1 = '0; bus_b.seg_ready = 1'b1;

        // Model pinned against hand-computed values.
        model_push(2, 64'h1000, 0, 256);
        chk("model tail addr", qs[0].addr, 64'h1000);
        chk("model tail size", qs[0].size, 8);
        chk("model tail pad", qs[0].pad, 7);
        qs.delete();
        model_push(2, 0, 36, 256);
        chk("model len36 size", qs[0].size, 64);
        chk("model len36 pad", qs[0].pad, 27);
        qs.delete();
        model_push(2, 64'h2000, 256, 256);
        chk("model split count", qs.size(), 2);
        chk("model split tail addr", qs[1].addr, 64'h2100);
        qs.delete();
        model_push(2, 0, 200, 128);
        chk("model max128 tail pad", qs[1].pad, 55);
        qs.delete();
        model_push(2, 64'h1003, 0, 256);
        chk("model unaligned addr", qs[0].addr, 64'h1000);
        qs.delete();

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset seg_valid", bus_a.seg_valid, 0);
        chk("reset req_ready", bus_a.req_ready, 0);
        chk("reset seg_addr", 64'(bus_a.seg_addr), 0);
        chk("reset seg_size", bus_a.seg_size, 0);
        chk("reset seg_pad", bus_a.seg_pad, 0);
        chk("reset seg_idx", bus_a.seg_idx, 0);
        chk("reset seg_last", bus_a.seg_last, 0);
        chk("reset err", bus_a.err_unaligned, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk("req_ready before first edge", bus_a.req_ready, 0);
        @(posedge clk); #1;
        chk("req_ready first cycle after reset a", bus_a.req_ready, 1);
        chk("req_ready first cycle after reset b", bus_b.req_ready, 1);

        run_xfer(0, 64'h1000, 0, 256, 1'b0);
        run_xfer(0, 64'h0, 255, 256, 1'b0);
        run_xfer(0, 64'h3000, 36, 256, 1'b0);
        run_xfer(0, 64'h2000, 256, 256, 1'b0);
        run_xfer(0, 64'h5000, 20'h2FF, 256, 1'b1);
        run_xfer(1, 64'h6000, 200, 128, 1'b0);
        run_xfer(1, 64'h7000, 7, 128, 1'b1);
        run_xfer(0, 64'h3_FFFF_FF00, 20'h1FF, 256, 1'b0);
        run_xfer(0, 64'h8000, 16, 256, 1'b0);

        // Reset while segment 1 of a four-segment transfer is stalled.
        model_push(0, 64'h4000, 20'h3FF, 256);
        set_rdy(0, 1'b1);
        send_req(0, 64'h4000, 20'h3FF);
        @(posedge clk); #1;
        set_rdy(0, 1'b0);
        @(negedge clk);
        chk("idx before reset", bus_a.seg_idx, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("seg_valid drops in reset", bus_a.seg_valid, 0);
        chk("req_ready low in reset", bus_a.req_ready, 0);
        chk("seg_addr cleared in reset", 64'(bus_a.seg_addr), 0);
        qa.delete();
        set_rdy(0, 1'b1);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        chk("req_ready after mid-transfer reset", bus_a.req_ready, 1);
        chk("no segment after reset", bus_a.seg_valid, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("still idle after reset", bus_a.seg_valid, 0);

        run_xfer(0, 64'h1003, 0, 256, 1'b0);
        run_xfer(0, 64'h2005, 20'h100, 256, 1'b0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
